hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Decode-side producer of the operand-forward and store-forward select codes that the D/X pipeline register captures, together with the stall and flush controls for F, D and X.
- Keeps a shadow pipeline of destination-register info for the X, M and W stages.
- Compares the D-stage instruction's sources against that shadow pipeline every cycle.
- Sits beside the decoder; its select outputs feed the D/X register select inputs, and the execute stage consumes them one cycle later.

Parameters:
- REG_ADDR_W, 5, register-index width.
- INST_W, 32, instruction width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- inst_D_i  in  INST_W  instruction currently in D.
- valid_D_i  in  1  D holds a real instruction (0 = bubble).
- redirect_X_i  in  1  taken branch/jump resolved in X this cycle.
- opforward_D_o  out  4  {rs1_sel[1:0], rs2_sel[1:0]}; captured by the D/X register.
- opforward_Dstore_o  out  2  store-data select for the M-stage memory write.
- stall_F_o  out  1  hold PC.
- stall_D_o  out  1  hold the F/D register.
- flush_D_o  out  1  kill the F/D contents.
- flush_X_o  out  1  load a bubble into the D/X register.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_ni=0, all shadow entries are invalid and all outputs are 0.
- Shadow entry per stage X, M, W: {v, rd, wen, is_load}.
  - Each cycle M<=X and W<=M.
  - X<=decoded D entry, or invalid when flush_X_o=1.
- Decode (sub-module, by opcode):
  - rs1_used: all except LUI, AUIPC, JAL.
  - rs2_used: R, STORE, BRANCH.
  - wen: R, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC.
  - is_load: LOAD. is_store: STORE.
  - wen is forced to 0 when rd=0, and also when valid_D_i=0.
- Match(S, r): shadow S has v & wen, and rd==r, and r!=0.
- Per-source select, evaluated only if the source is used, else 00:
  - 01 if Match(X): producer is in M when the consumer is in X; take the ALU result from M.
  - else 10 if Match(M): take the writeback data from W.
  - else 00: register file. The register file writes through, so a producer in W needs no forward.
  - X has priority over M.
- Load-use: stall=1 when the X entry is_load and Match(X) holds for any used source of D.
  - Exception: the only matching source is store data (rs2 of a STORE, rs1 not matching), gated by the optional feature.
  - On stall: stall_F_o=stall_D_o=1, flush_X_o=1, and opforward outputs=0.
  - Next cycle the load is in M, the select becomes 10, and there is no second stall.
- Redirect: redirect_X_i=1 gives flush_D_o=1 and flush_X_o=1.
  - Redirect overrides stall: stall_F_o=stall_D_o=0.
  - The instruction in D is not entered into the shadow pipeline.
- All outputs are combinational from shadow state plus inst_D_i/redirect_X_i; the shadow state updates on the clock edge.
- Latency:
  - Select codes are valid in the same cycle as the instruction in D.
  - Stall lasts exactly 1 cycle per load-use.
- Reset mid-operation: shadow entries are cleared asynchronously and no stale forward is issued after release.

Optional Feature:
- Macro LOAD_STORE_FWD_EN.
- Defined: a STORE whose rs2 matches a load in X does not stall. Its rs2_sel is 00 and opforward_Dstore_o=01, meaning the store data is taken from the W writeback at M.
- Undefined: this case stalls like any load-use, and opforward_Dstore_o is always 00.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM);
  - fwd_sel_e enum (FWD_RF=00, FWD_M=01, FWD_W=10);
  - struct shadow_entry_t.
- One sub-module, hazard_inst_decode: combinational rs1/rs2/rd extraction plus the used/wen/load/store flags.

Test Plan:
- ADD x5 in X, then ADD x6,x5,x5 in D -> opforward_D_o=4'b0101, no stall.
- ADD x5 in M, X bubble, then SUB x7,x5,x1 in D -> opforward_D_o=4'b1000.
- LW x5 in X, then ADD x6,x5,x0 in D:
  - stall_F_o=stall_D_o=flush_X_o=1 for 1 cycle;
  - the following cycle opforward_D_o=4'b1000 and stall=0.
- Write to x0 in X, then ADD x1,x0,x0 in D -> opforward_D_o=0000.
- redirect_X_i=1 coincident with a load-use:
  - flush_D_o=flush_X_o=1, stall=0;
  - next cycle the shadow X entry is invalid.
- LW x5 in X, then SW x5,0(x2) in D:
  - with LOAD_STORE_FWD_EN: no stall, opforward_Dstore_o=01;
  - without it: 1-cycle stall, opforward_Dstore_o=00.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared opcode constants, forward-select encoding and the shadow-pipeline entry
// type used by the hazard/forward unit.
package riscv_pkg;

  localparam int unsigned RF_AW = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic             v;
    logic [RF_AW-1:0] rd;
    logic             wen;
    logic             is_load;
  } shadow_entry_t;

  // x0 is hardwired, so it never matches a producer.
  function automatic logic entry_match(shadow_entry_t e, logic [RF_AW-1:0] r);
    return e.v & e.wen & (e.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/hazard_inst_decode.sv
// Combinational field extraction and hazard-relevant flags for the D-stage instruction.
module hazard_inst_decode
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned INST_W     = 32
) (
  input  logic [INST_W-1:0]     inst_i,
  input  logic                  valid_i,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  rs1_used_o,
  output logic                  rs2_used_o,
  output logic                  wen_o,
  output logic                  is_load_o,
  output logic                  is_store_o
);

  logic [6:0] opc;
  logic       rs1u, rs2u, wen, ld, st;
  logic       unused_bits;

  assign opc         = inst_i[6:0];
  assign rd_o        = inst_i[7 +: REG_ADDR_W];
  assign rs1_o       = inst_i[15 +: REG_ADDR_W];
  assign rs2_o       = inst_i[20 +: REG_ADDR_W];
  assign unused_bits = ^{inst_i[INST_W-1:25], inst_i[14:12]};

  always_comb begin
    rs1u = 1'b0;
    rs2u = 1'b0;
    wen  = 1'b0;
    ld   = 1'b0;
    st   = 1'b0;
    case (opc)
      OPC_OP:     begin rs1u = 1'b1; rs2u = 1'b1; wen = 1'b1; end
      OPC_OPIMM:  begin rs1u = 1'b1; wen = 1'b1; end
      OPC_LOAD:   begin rs1u = 1'b1; wen = 1'b1; ld = 1'b1; end
      OPC_STORE:  begin rs1u = 1'b1; rs2u = 1'b1; st = 1'b1; end
      OPC_BRANCH: begin rs1u = 1'b1; rs2u = 1'b1; end
      OPC_JAL:    wen = 1'b1;
      OPC_JALR:   begin rs1u = 1'b1; wen = 1'b1; end
      OPC_LUI:    wen = 1'b1;
      OPC_AUIPC:  wen = 1'b1;
      default:    rs1u = 1'b1;
    endcase
  end

  // A bubble neither consumes nor produces anything.
  assign rs1_used_o = valid_i & rs1u;
  assign rs2_used_o = valid_i & rs2u;
  assign wen_o      = valid_i & wen & (rd_o != '0);
  assign is_load_o  = valid_i & ld;
  assign is_store_o = valid_i & st;

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand/store forward selects plus stall/flush controls from an X/M/W shadow pipeline.
// Optional macro LOAD_STORE_FWD_EN: load->store-data forwarding without a stall.
module hazard_forward_unit
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned INST_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [INST_W-1:0] inst_D_i,
  input  logic              valid_D_i,
  input  logic              redirect_X_i,
  output logic [3:0]        opforward_D_o,
  output logic [1:0]        opforward_Dstore_o,
  output logic              stall_F_o,
  output logic              stall_D_o,
  output logic              flush_D_o,
  output logic              flush_X_o
);

  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  rs1_used, rs2_used, wen, is_load, is_store;
  shadow_entry_t         sh_x, sh_m, sh_w, d_entry;
  fwd_sel_e              sel1, sel2;
  logic                  m1x, m1m, m2x, m2m, lu1, lu2, st_fwd, load_use, flush_x;
  logic [1:0]            dstore;
  logic                  unused_w;

  hazard_inst_decode #(
    .REG_ADDR_W (REG_ADDR_W),
    .INST_W     (INST_W)
  ) u_dec (
    .inst_i     (inst_D_i),
    .valid_i    (valid_D_i),
    .rs1_o      (rs1),
    .rs2_o      (rs2),
    .rd_o       (rd),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used),
    .wen_o      (wen),
    .is_load_o  (is_load),
    .is_store_o (is_store)
  );

  assign d_entry = '{v: valid_D_i, rd: rd, wen: wen, is_load: is_load};

  // W is tracked for completeness; the register file writes through, so it never forwards.
  assign unused_w = ^sh_w;

  assign m1x = entry_match(sh_x, rs1);
  assign m1m = entry_match(sh_m, rs1);
  assign m2x = entry_match(sh_x, rs2);
  assign m2m = entry_match(sh_m, rs2);

  always_comb begin
    sel1 = FWD_RF;
    sel2 = FWD_RF;
    if (rs1_used) sel1 = m1x ? FWD_M : (m1m ? FWD_W : FWD_RF);
    if (rs2_used) sel2 = m2x ? FWD_M : (m2m ? FWD_W : FWD_RF);

    lu1 = sh_x.is_load & rs1_used & m1x;
    lu2 = sh_x.is_load & rs2_used & m2x;
`ifdef LOAD_STORE_FWD_EN
    // Store data is needed only in M, when the load result is already on the W bus.
    st_fwd = is_store & lu2 & ~lu1;
`else
    st_fwd = 1'b0;
`endif
    dstore = '0;
    if (st_fwd) begin
      sel2   = FWD_RF;
      dstore = 2'b01;
    end
    load_use = (lu1 | lu2) & ~st_fwd;
    flush_x  = load_use | redirect_X_i;
  end

`ifndef LOAD_STORE_FWD_EN
  logic unused_store;
  assign unused_store = is_store;
`endif

  assign opforward_D_o      = (rst_ni & ~load_use) ? {sel1, sel2} : '0;
  assign opforward_Dstore_o = (rst_ni & ~load_use) ? dstore : '0;
  assign stall_F_o          = rst_ni & load_use & ~redirect_X_i;
  assign stall_D_o          = rst_ni & load_use & ~redirect_X_i;
  assign flush_D_o          = rst_ni & redirect_X_i;
  assign flush_X_o          = rst_ni & flush_x;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_x <= '0;
      sh_m <= '0;
      sh_w <= '0;
    end else begin
      sh_w <= sh_m;
      sh_m <= sh_x;
      sh_x <= flush_x ? '0 : d_entry;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; expectations honour LOAD_STORE_FWD_EN.
module tb_hazard_forward_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] inst_D_i;
  logic        valid_D_i;
  logic        redirect_X_i;
  logic [3:0]  opforward_D_o;
  logic [1:0]  opforward_Dstore_o;
  logic        stall_F_o, stall_D_o, flush_D_o, flush_X_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  hazard_forward_unit #(
    .REG_ADDR_W (5),
    .INST_W     (32)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .inst_D_i           (inst_D_i),
    .valid_D_i          (valid_D_i),
    .redirect_X_i       (redirect_X_i),
    .opforward_D_o      (opforward_D_o),
    .opforward_Dstore_o (opforward_Dstore_o),
    .stall_F_o          (stall_F_o),
    .stall_D_o          (stall_D_o),
    .flush_D_o          (flush_D_o),
    .flush_X_o          (flush_X_o)
  );

  function automatic logic [31:0] i_add(input logic [4:0] rd, rs1, rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_sub(input logic [4:0] rd, rs1, rs2);
    return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_lw(input logic [4:0] rd, rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rs2, rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] i_lui_f(input logic [4:0] rd, field);
    return {12'd0, field, 3'b000, rd, 7'b0110111};
  endfunction

  task automatic set(input logic [31:0] inst, input logic v, input logic r);
    inst_D_i     = inst;
    valid_D_i    = v;
    redirect_X_i = r;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drain();
    set(32'd0, 1'b0, 1'b0);
    tick(); tick(); tick();
  endtask

  // Packed as {op[3:0], dstore[1:0], stall_F, stall_D, flush_D, flush_X}.
  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    #1;
    obs = {opforward_D_o, opforward_Dstore_o, stall_F_o, stall_D_o, flush_D_o, flush_X_o};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    set(i_add(5'd6, 5'd5, 5'd5), 1'b1, 1'b1);
    #12;
    chk("reset_outputs", 10'b0000_00_0000);
    set(32'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drain();

    // X producer feeds both sources
    set(i_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b0); tick();
    set(i_add(5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
    chk("fwd_x_both", 10'b0101_00_0000);

    drain();
    set(i_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b0); tick();
    set(32'd0, 1'b0, 1'b0); tick();
    set(i_sub(5'd7, 5'd5, 5'd1), 1'b1, 1'b0);
    chk("fwd_m_rs1", 10'b1000_00_0000);

    // X wins over M for the same register
    drain();
    set(i_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b0); tick();
    set(i_add(5'd5, 5'd3, 5'd4), 1'b1, 1'b0);
    chk("no_dep", 10'b0000_00_0000);
    tick();
    set(i_add(5'd6, 5'd5, 5'd0), 1'b1, 1'b0);
    chk("x_over_m", 10'b0100_00_0000);
    set(i_add(5'd6, 5'd3, 5'd5), 1'b1, 1'b0);
    chk("x_rs2", 10'b0001_00_0000);

    // load-use: one stall, then forward from W
    drain();
    set(i_lw(5'd5, 5'd1), 1'b1, 1'b0); tick();
    set(i_add(5'd6, 5'd5, 5'd0), 1'b1, 1'b0);
    chk("lu_stall", 10'b0000_00_1101);
    tick();
    chk("lu_after", 10'b1000_00_0000);
    tick();
    chk("lu_gone", 10'b0000_00_0000);

    // x0 never forwards
    drain();
    set(i_add(5'd0, 5'd1, 5'd2), 1'b1, 1'b0); tick();
    set(i_add(5'd1, 5'd0, 5'd0), 1'b1, 1'b0);
    chk("x0_no_fwd", 10'b0000_00_0000);
    drain();
    set(i_lw(5'd0, 5'd1), 1'b1, 1'b0); tick();
    set(i_add(5'd1, 5'd0, 5'd0), 1'b1, 1'b0);
    chk("x0_load_no_stall", 10'b0000_00_0000);

    // LUI does not read rs1 even when its bits coincide with a producer
    drain();
    set(i_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b0); tick();
    set(i_lui_f(5'd6, 5'd5), 1'b1, 1'b0);
    chk("lui_rs1_unused", 10'b0000_00_0000);

    // redirect overrides load-use and kills the D instruction
    drain();
    set(i_lw(5'd5, 5'd1), 1'b1, 1'b0); tick();
    set(i_add(5'd6, 5'd5, 5'd0), 1'b1, 1'b1);
    chk("redir_lu", 10'b0000_00_0011);
    tick();
    set(i_add(5'd7, 5'd6, 5'd5), 1'b1, 1'b0);
    chk("redir_x_invalid", 10'b0010_00_0000);

    // load feeding store data
    drain();
    set(i_lw(5'd5, 5'd1), 1'b1, 1'b0); tick();
    set(i_sw(5'd5, 5'd2), 1'b1, 1'b0);
`ifdef LOAD_STORE_FWD_EN
    chk("ld_st_data", 10'b0000_01_0000);
    tick();
    set(32'd0, 1'b0, 1'b0);
    chk("ld_st_next", 10'b0000_00_0000);
`else
    chk("ld_st_data", 10'b0000_00_1101);
    tick();
    chk("ld_st_next", 10'b0010_00_0000);
`endif

    // load feeding the store address always stalls
    drain();
    set(i_lw(5'd5, 5'd1), 1'b1, 1'b0); tick();
    set(i_sw(5'd3, 5'd5), 1'b1, 1'b0);
    chk("ld_st_addr", 10'b0000_00_1101);

    // asynchronous reset mid-stream leaves no stale forward
    drain();
    set(i_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b0); tick();
    set(i_add(5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
    chk("pre_reset", 10'b0101_00_0000);
    rst_ni = 1'b0;
    chk("mid_reset", 10'b0000_00_0000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("post_reset", 10'b0000_00_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
